bus_booking_server: RTL and testbench
=====================================

// Module: bus_booking_server
// PURPOSE
//  Server-side responder for the bus booking flow. It receives seat requests, holds the seat while payment is pending,
//  then confirms or releases it and reports the result. It owns the seat occupancy map and the free-seat count.
//  It sits behind the user-side booking FSM and takes one booking transaction at a time.
// PARAMETERS
//  NUM_SEATS    40  number of seats on the bus, indices 0..NUM_SEATS-1
//  SEAT_W       6   seat index width; must satisfy 2**SEAT_W >= NUM_SEATS+1
//  PAY_TIMEOUT  16  cycles spent in HOLD with no payment/cancel before the hold expires (>=2)
//  TO_W         5   timeout counter width; must satisfy 2**TO_W > PAY_TIMEOUT
// PORTS
//  clk          in   1         single clock, all logic on posedge
//  rst          in   1         synchronous, active-high reset
//  req_valid    in   1         seat request strobe, sampled only when req_ready=1
//  req_seat     in   SEAT_W    requested seat index
//  req_ready    out  1         1 only in IDLE
//  pay_valid    in   1         payment result strobe, meaningful only in HOLD
//  pay_ok       in   1         1 = payment success, 0 = payment failed
//  cancel       in   1         user abort, meaningful only in HOLD
//  rel_valid    in   1         release a previously confirmed seat
//  rel_seat     in   SEAT_W    seat index to release
//  rel_ready    out  1         state==IDLE && !req_valid
//  resp_valid   out  1         one-cycle response pulse
//  resp_status  out  2         00 booked, 01 rejected (taken/invalid), 10 released (pay fail/cancel), 11 timeout
//  resp_seat    out  SEAT_W    seat index the response refers to
//  seats_free   out  SEAT_W+1  count of free seats
//  full         out  1         seats_free==0
// BEHAVIOUR
//  Reset (synchronous, rst=1 at posedge):
//   - state=IDLE, seat map all free, timer=0.
//   - resp_valid=0, resp_status=00, resp_seat=0.
//   - seats_free=NUM_SEATS, full=0.
//   - Reset mid-transaction discards the hold and every booking. No response is emitted.
//  States: IDLE -> CHECK -> (HOLD | RESP) ; HOLD -> RESP ; RESP -> IDLE. All outputs are registered.
//  IDLE:
//   - req_valid=1: latch req_seat, go to CHECK.
//   - Else rel_valid=1: if rel_seat<NUM_SEATS and the seat is occupied, clear it and increment seats_free.
//     An invalid or free seat is ignored silently. The release produces no response and the state stays IDLE.
//   - req_valid and rel_valid in the same cycle: the request wins and the release is dropped (rel_ready=0).
//  CHECK (exactly 1 cycle):
//   - Seat >= NUM_SEATS, or seat occupied: go to RESP with status 01.
//   - Otherwise mark the seat occupied, decrement seats_free, clear the timer, go to HOLD.
//  HOLD:
//   - Priority is cancel > pay_valid > timeout.
//   - cancel=1: free the seat, increment seats_free, go to RESP with status 10.
//   - pay_valid & pay_ok: the seat stays occupied; go to RESP with status 00.
//   - pay_valid & !pay_ok: free the seat, go to RESP with status 10.
//   - Otherwise increment the timer. When timer==PAY_TIMEOUT-1 with no event: free the seat, go to RESP with status 11.
//  RESP:
//   - resp_valid=1 for exactly one cycle, with resp_seat = the latched seat. Then return to IDLE.
//   - resp_status and resp_seat hold their values until the next response.
//  Latency:
//   - Request accepted at cycle N. A reject gives resp_valid at N+2.
//   - A payment event at HOLD cycle M gives resp_valid at M+1.
//  Width/arith:
//   - seats_free never wraps. A decrement happens only on a free seat; an increment only on an occupied seat.
//   - full is updated in the same cycle as seats_free.
//   - A full bus still accepts requests and rejects them with 01.
//  pay_valid, cancel and rel_valid outside the state where they are meaningful: ignored.
// TESTING
//  T1: reset, req seat 5, pay_valid=1 pay_ok=1 on the 3rd HOLD cycle -> one resp_valid pulse, status 00, seat 5,
//      seats_free=39.
//  T2: req seat 5 again -> status 01, resp_valid 2 cycles after accept, seats_free stays 39.
//      req seat 40 -> status 01.
//  T3: req seat 7 with no payment -> status 11 after 16 HOLD cycles, seats_free returns to 39.
//  T4: req seat 8, cancel=1 and pay_valid=1 pay_ok=1 in the same cycle -> status 10, seat 8 free
//      (a later req 8 plus pay succeeds).
//  T5: book all 40 seats -> full=1, seats_free=0, next req -> 01. rel seat 0 -> full=0, seats_free=1.
//      req_valid and rel_valid together -> release dropped.
//  T6: rst=1 during HOLD for seat 3 -> no resp_valid, seats_free=40, state IDLE, req_ready=1 on the next cycle.

Source files
------------

// File: rtl/bus_booking_server.sv
// Server-side seat booking responder: checks a requested seat, holds it while
// payment is pending, then confirms or frees it and emits a one-cycle response.
module bus_booking_server #(
    parameter int NUM_SEATS   = 40,
    parameter int SEAT_W      = 6,
    parameter int PAY_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [SEAT_W-1:0] req_seat,
    output logic              req_ready,
    input  logic              pay_valid,
    input  logic              pay_ok,
    input  logic              cancel,
    input  logic              rel_valid,
    input  logic [SEAT_W-1:0] rel_seat,
    output logic              rel_ready,
    output logic              resp_valid,
    output logic [1:0]        resp_status,
    output logic [SEAT_W-1:0] resp_seat,
    output logic [SEAT_W:0]   seats_free,
    output logic              full,
    output logic [1:0]        dbg_state
);

    // Handshake: a request is taken on any posedge where req_valid && req_ready;
    // a release is taken where rel_valid && rel_ready. resp_valid is a one-cycle
    // pulse with no back-pressure.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_HOLD  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] ST_BOOKED   = 2'b00;
    localparam logic [1:0] ST_REJECTED = 2'b01;
    localparam logic [1:0] ST_RELEASED = 2'b10;
    localparam logic [1:0] ST_TIMEOUT  = 2'b11;

    localparam logic [SEAT_W-1:0] SEAT_LIMIT = SEAT_W'(NUM_SEATS);
    localparam logic [SEAT_W:0]   FREE_INIT  = (SEAT_W + 1)'(NUM_SEATS);
    localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(PAY_TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [NUM_SEATS-1:0] map_q, map_d;
    logic [SEAT_W:0]      free_q, free_d;
    logic                 full_q, full_d;
    logic [SEAT_W-1:0]    seat_q, seat_d;
    logic [TO_W-1:0]      timer_q, timer_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [1:0]           status_q, status_d;
    logic [SEAT_W-1:0]    resp_seat_q, resp_seat_d;

    logic seat_in_range;
    logic rel_in_range;

    assign seat_in_range = (seat_q < SEAT_LIMIT);
    assign rel_in_range  = (rel_seat < SEAT_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            map_q        <= '0;
            free_q       <= FREE_INIT;
            full_q       <= 1'b0;
            seat_q       <= '0;
            timer_q      <= '0;
            resp_valid_q <= 1'b0;
            status_q     <= ST_BOOKED;
            resp_seat_q  <= '0;
        end else begin
            state_q      <= state_d;
            map_q        <= map_d;
            free_q       <= free_d;
            full_q       <= full_d;
            seat_q       <= seat_d;
            timer_q      <= timer_d;
            resp_valid_q <= resp_valid_d;
            status_q     <= status_d;
            resp_seat_q  <= resp_seat_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        map_d        = map_q;
        free_d       = free_q;
        seat_d       = seat_q;
        timer_d      = timer_q;
        resp_valid_d = 1'b0;
        status_d     = status_q;
        resp_seat_d  = resp_seat_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    seat_d  = req_seat;
                    state_d = S_CHECK;
                end else if (rel_valid && rel_in_range && map_q[rel_seat]) begin
                    map_d[rel_seat] = 1'b0;
                    free_d          = free_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (!seat_in_range || map_q[seat_q]) begin
                    status_d     = ST_REJECTED;
                    resp_seat_d  = seat_q;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    map_d[seat_q] = 1'b1;
                    free_d        = free_q - 1'b1;
                    timer_d       = '0;
                    state_d       = S_HOLD;
                end
            end
            S_HOLD: begin
                // Any exit from HOLD except a good payment gives the seat back.
                if (cancel || (pay_valid && !pay_ok) || (!pay_valid && timer_q == TO_LAST)) begin
                    map_d[seat_q] = 1'b0;
                    free_d        = free_q + 1'b1;
                end
                if (cancel || pay_valid || timer_q == TO_LAST) begin
                    resp_seat_d  = seat_q;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end
                if (cancel) begin
                    status_d = ST_RELEASED;
                end else if (pay_valid) begin
                    status_d = pay_ok ? ST_BOOKED : ST_RELEASED;
                end else if (timer_q == TO_LAST) begin
                    status_d = ST_TIMEOUT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        full_d = (free_d == '0);
    end

    assign req_ready   = (state_q == S_IDLE);
    assign rel_ready   = (state_q == S_IDLE) && !req_valid;
    assign resp_valid  = resp_valid_q;
    assign resp_status = status_q;
    assign resp_seat   = resp_seat_q;
    assign seats_free  = free_q;
    assign full        = full_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_bus_booking_server.sv
// Directed bench for bus_booking_server: booking, reject, timeout, cancel,
// full bus, release and mid-transaction reset, all with hand-computed results.
module tb_bus_booking_server;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [5:0] req_seat = '0;
    logic       req_ready;
    logic       pay_valid = 1'b0;
    logic       pay_ok = 1'b0;
    logic       cancel = 1'b0;
    logic       rel_valid = 1'b0;
    logic [5:0] rel_seat = '0;
    logic       rel_ready;
    logic       resp_valid;
    logic [1:0] resp_status;
    logic [5:0] resp_seat;
    logic [6:0] seats_free;
    logic       full;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    bus_booking_server dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_seat   (req_seat),
        .req_ready  (req_ready),
        .pay_valid  (pay_valid),
        .pay_ok     (pay_ok),
        .cancel     (cancel),
        .rel_valid  (rel_valid),
        .rel_seat   (rel_seat),
        .rel_ready  (rel_ready),
        .resp_valid (resp_valid),
        .resp_status(resp_status),
        .resp_seat  (resp_seat),
        .seats_free (seats_free),
        .full       (full),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one cycle; returns with the DUT in CHECK.
    task automatic send_req(input logic [5:0] s);
        req_valid = 1'b1;
        req_seat  = s;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic book(input logic [5:0] s);
        send_req(s);
        tick();
        pay_valid = 1'b1;
        pay_ok    = 1'b1;
        tick();
        pay_valid = 1'b0;
        pay_ok    = 1'b0;
        check("book_valid", resp_valid, 1);
        check("book_status", resp_status, 0);
        check("book_seat", resp_seat, s);
        tick();
    endtask

    task automatic release_seat(input logic [5:0] s);
        rel_valid = 1'b1;
        rel_seat  = s;
        tick();
        rel_valid = 1'b0;
    endtask

    initial begin
        int n;
        // T1: reset, then book seat 5 with payment on the 3rd HOLD cycle
        tick();
        tick();
        rst = 1'b0;
        check("rst_req_ready", req_ready, 1);
        check("rst_rel_ready", rel_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_status", resp_status, 0);
        check("rst_seat", resp_seat, 0);
        check("rst_free", seats_free, 40);
        check("rst_full", full, 0);
        check("rst_state", dbg_state, 0);

        send_req(6'd5);
        check("t1_check_state", dbg_state, 1);
        check("t1_check_ready", req_ready, 0);
        tick();
        check("t1_hold_state", dbg_state, 2);
        check("t1_hold_free", seats_free, 39);
        check("t1_hold_resp", resp_valid, 0);
        tick();
        tick();
        pay_valid = 1'b1;
        pay_ok    = 1'b1;
        tick();
        pay_valid = 1'b0;
        pay_ok    = 1'b0;
        check("t1_resp_valid", resp_valid, 1);
        check("t1_status", resp_status, 0);
        check("t1_seat", resp_seat, 5);
        check("t1_free", seats_free, 39);
        tick();
        check("t1_pulse_end", resp_valid, 0);
        check("t1_status_hold", resp_status, 0);
        check("t1_back_idle", req_ready, 1);

        // T2: rejects for a taken seat and an out-of-range seat
        send_req(6'd5);
        check("t2_no_early_resp", resp_valid, 0);
        tick();
        check("t2_taken_valid", resp_valid, 1);
        check("t2_taken_status", resp_status, 1);
        check("t2_taken_seat", resp_seat, 5);
        check("t2_taken_free", seats_free, 39);
        tick();
        check("t2_taken_pulse_end", resp_valid, 0);
        send_req(6'd40);
        tick();
        check("t2_range_valid", resp_valid, 1);
        check("t2_range_status", resp_status, 1);
        check("t2_range_seat", resp_seat, 40);
        check("t2_range_free", seats_free, 39);
        tick();

        // T3: seat 7 never paid -> timeout after 16 HOLD cycles
        send_req(6'd7);
        tick();
        check("t3_hold_free", seats_free, 38);
        n = 0;
        while (!resp_valid && n < 40) begin
            tick();
            n++;
        end
        check("t3_resp_seen", resp_valid, 1);
        check("t3_hold_cycles", n, 16);
        check("t3_status", resp_status, 3);
        check("t3_seat", resp_seat, 7);
        check("t3_free", seats_free, 39);
        tick();

        // T4: cancel beats a simultaneous good payment
        send_req(6'd8);
        tick();
        cancel    = 1'b1;
        pay_valid = 1'b1;
        pay_ok    = 1'b1;
        tick();
        cancel    = 1'b0;
        pay_valid = 1'b0;
        pay_ok    = 1'b0;
        check("t4_valid", resp_valid, 1);
        check("t4_status", resp_status, 2);
        check("t4_seat", resp_seat, 8);
        check("t4_free", seats_free, 39);
        tick();
        book(6'd8);
        check("t4_rebook_free", seats_free, 38);

        // T5: fill the bus, reject on full, release, release dropped on collision
        for (int s = 0; s < 40; s++) begin
            if (s != 5 && s != 8) book(6'(s));
        end
        check("t5_full", full, 1);
        check("t5_free0", seats_free, 0);
        send_req(6'd20);
        tick();
        check("t5_full_reject", resp_status, 1);
        check("t5_full_reject_v", resp_valid, 1);
        check("t5_full_still", full, 1);
        tick();
        #1;
        check("t5_rel_ready", rel_ready, 1);
        release_seat(6'd0);
        check("t5_rel_free", seats_free, 1);
        check("t5_rel_full", full, 0);
        release_seat(6'd45);
        check("t5_rel_invalid", seats_free, 1);
        release_seat(6'd0);
        check("t5_rel_already_free", seats_free, 1);

        req_valid = 1'b1;
        req_seat  = 6'd0;
        rel_valid = 1'b1;
        rel_seat  = 6'd1;
        #1;
        check("t5_collide_rel_ready", rel_ready, 0);
        tick();
        req_valid = 1'b0;
        rel_valid = 1'b0;
        tick();
        check("t5_collide_hold", dbg_state, 2);
        check("t5_collide_free", seats_free, 0);
        check("t5_collide_full", full, 1);
        pay_valid = 1'b1;
        pay_ok    = 1'b0;
        tick();
        pay_valid = 1'b0;
        check("t5_payfail_status", resp_status, 2);
        check("t5_payfail_seat", resp_seat, 0);
        check("t5_payfail_free", seats_free, 1);
        tick();

        // T6: reset during HOLD of seat 3
        release_seat(6'd3);
        check("t6_rel_free", seats_free, 2);
        send_req(6'd3);
        tick();
        check("t6_hold", dbg_state, 2);
        check("t6_hold_free", seats_free, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_resp", resp_valid, 0);
        check("t6_rst_free", seats_free, 40);
        check("t6_rst_full", full, 0);
        check("t6_rst_state", dbg_state, 0);
        check("t6_rst_ready", req_ready, 1);
        tick();
        check("t6_post_resp", resp_valid, 0);
        check("t6_post_ready", req_ready, 1);
        book(6'd3);
        check("t6_rebook_free", seats_free, 39);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
